counter_readout: RTL and testbench



---
 rtl/counter_readout.sv | 148 ++++++++++++++
 tb/tb_counter_readout.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/counter_readout.sv
// Snapshots two 64-bit event counters on request and streams them as a byte-wide framed packet.
// Optional trailing XOR checksum byte: define COUNTER_READOUT_CHECKSUM_EN.
module counter_readout #(
   parameter logic [7:0] HEADER = 8'hA5
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [63:0] Cnt0,
   input  logic [63:0] Cnt1,
   input  logic        Req,
   input  logic        DReady,
   output logic [7:0]  DOut,
   output logic        DValid,
   output logic        Busy,
   output logic        Drop
);

`ifdef COUNTER_READOUT_CHECKSUM_EN
   typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_CSUM} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;
`endif

   state_t       r_state, w_state_next;
   logic [3:0]   r_idx, w_idx_next;
   logic [63:0]  r_snap0, r_snap1;
   logic [7:0]   r_dout, w_dout_next;
   logic         r_dvalid, w_dvalid_next;
   logic         r_drop;
   logic         w_load;
   logic         w_accept;
   logic [127:0] w_frame;
   logic [3:0]   w_cur_sel, w_nxt_sel;
   logic [7:0]   w_cur_byte, w_nxt_byte;
`ifdef COUNTER_READOUT_CHECKSUM_EN
   logic [7:0]   r_csum, w_csum_next;
`endif

   // Byte index 0 is the MSB of snapshot0; index 15 is the LSB of snapshot1.
   assign w_frame    = {r_snap0, r_snap1};
   assign w_cur_sel  = 4'd15 - r_idx;
   assign w_nxt_sel  = 4'd14 - r_idx;
   assign w_cur_byte = w_frame[{w_cur_sel, 3'b000} +: 8];
   assign w_nxt_byte = w_frame[{w_nxt_sel, 3'b000} +: 8];
   assign w_accept   = r_dvalid & DReady;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state  <= S_IDLE;
         r_idx    <= 4'd0;
         r_snap0  <= 64'd0;
         r_snap1  <= 64'd0;
         r_dout   <= 8'd0;
         r_dvalid <= 1'b0;
         r_drop   <= 1'b0;
`ifdef COUNTER_READOUT_CHECKSUM_EN
         r_csum   <= 8'd0;
`endif
      end else begin
         r_state  <= w_state_next;
         r_idx    <= w_idx_next;
         r_dout   <= w_dout_next;
         r_dvalid <= w_dvalid_next;
         r_drop   <= Req & (r_state != S_IDLE);
         if (w_load) begin
            r_snap0 <= Cnt0;
            r_snap1 <= Cnt1;
         end
`ifdef COUNTER_READOUT_CHECKSUM_EN
         r_csum   <= w_csum_next;
`endif
      end
   end

   // Outputs are registered, so each branch computes the byte shown after the edge.
   always_comb begin
      w_state_next  = r_state;
      w_idx_next    = r_idx;
      w_dout_next   = r_dout;
      w_dvalid_next = r_dvalid;
      w_load        = 1'b0;
`ifdef COUNTER_READOUT_CHECKSUM_EN
      w_csum_next   = r_csum;
`endif
      case (r_state)
         S_IDLE: begin
            w_dout_next   = 8'd0;
            w_dvalid_next = 1'b0;
            if (Req) begin
               w_load        = 1'b1;
               w_state_next  = S_HDR;
               w_dout_next   = HEADER;
               w_dvalid_next = 1'b1;
`ifdef COUNTER_READOUT_CHECKSUM_EN
               w_csum_next   = 8'd0;
`endif
            end
         end
         S_HDR: begin
            if (w_accept) begin
               w_state_next = S_DATA;
               w_idx_next   = 4'd0;
               w_dout_next  = w_frame[127:120];
            end
         end
         S_DATA: begin
            if (w_accept) begin
`ifdef COUNTER_READOUT_CHECKSUM_EN
               w_csum_next = r_csum ^ w_cur_byte;
`endif
               if (r_idx == 4'd15) begin
`ifdef COUNTER_READOUT_CHECKSUM_EN
                  w_state_next = S_CSUM;
                  w_dout_next  = r_csum ^ w_cur_byte;
`else
                  w_state_next  = S_IDLE;
                  w_dout_next   = 8'd0;
                  w_dvalid_next = 1'b0;
`endif
               end else begin
                  w_idx_next  = r_idx + 4'd1;
                  w_dout_next = w_nxt_byte;
               end
            end
         end
`ifdef COUNTER_READOUT_CHECKSUM_EN
         S_CSUM: begin
            if (w_accept) begin
               w_state_next  = S_IDLE;
               w_dout_next   = 8'd0;
               w_dvalid_next = 1'b0;
            end
         end
`endif
         default: begin
            w_state_next  = S_IDLE;
            w_dout_next   = 8'd0;
            w_dvalid_next = 1'b0;
         end
      endcase
   end

   assign DOut   = r_dout;
   assign DValid = r_dvalid;
   assign Busy   = (r_state != S_IDLE);
   assign Drop   = r_drop;

endmodule

// File: tb/tb_counter_readout.sv
// Scoreboard bench for counter_readout: a frame-level model queues expected bytes, a monitor checks the stream.
// Builds with or without COUNTER_READOUT_CHECKSUM_EN.
module tb_counter_readout;

`ifdef COUNTER_READOUT_CHECKSUM_EN
   localparam int FLEN = 18;
`else
   localparam int FLEN = 17;
`endif

   logic        Clk = 1'b0;
   logic        Reset;
   logic [63:0] Cnt0, Cnt1;
   logic        Req, DReady;
   logic [7:0]  DOut;
   logic        DValid, Busy, Drop;

   counter_readout #(.HEADER(8'hA5)) dut (
      .Clk(Clk), .Reset(Reset), .Cnt0(Cnt0), .Cnt1(Cnt1), .Req(Req),
      .DReady(DReady), .DOut(DOut), .DValid(DValid), .Busy(Busy), .Drop(Drop)
   );

   always #5 Clk = ~Clk;

   int         n_chk = 0;
   int         n_err = 0;
   int         n_frames = 0;
   logic [7:0] exp_q[$];
   int         m_left = 0;
   logic       m_drop = 1'b0;
   logic       mon_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Expected frame: header, snapshot bytes MSB first, optional XOR of data bytes.
   task automatic push_frame(input logic [63:0] a, input logic [63:0] b);
      logic [7:0] x;
      logic [7:0] data [16];
      x = 8'd0;
      for (int i = 0; i < 8; i++) begin
         data[i]     = a[63 - 8*i -: 8];
         data[i + 8] = b[63 - 8*i -: 8];
      end
      exp_q.push_back(8'hA5);
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back(data[i]);
         x = x ^ data[i];
      end
`ifdef COUNTER_READOUT_CHECKSUM_EN
      exp_q.push_back(x);
`endif
      n_frames++;
      $display("frame %0d issued at %0t: cnt0=%h cnt1=%h csum=%h", n_frames, $time, a, b, x);
   endtask

   // Reference model: advances on every clock edge from the inputs alone.
   initial begin
      forever begin
         @(posedge Clk);
         if (Reset) begin
            m_left = 0;
            m_drop = 1'b0;
            exp_q.delete();
            mon_en = 1'b1;
         end else if (m_left > 0) begin
            m_drop = Req;
            if (DReady) m_left--;
         end else begin
            m_drop = 1'b0;
            if (Req) begin
               push_frame(Cnt0, Cnt1);
               m_left = FLEN;
            end
         end
      end
   end

   // Monitor: compares DUT outputs mid-cycle and retires a byte on each accept.
   initial begin
      forever begin
         @(negedge Clk);
         if (mon_en) begin
            chk("busy", Busy, 64'(m_left > 0));
            chk("dvalid", DValid, 64'(m_left > 0));
            chk("drop", Drop, 64'(m_drop));
            if (m_left > 0 && exp_q.size() > 0) begin
               chk("dout", DOut, 64'(exp_q[0]));
               if (DReady) void'(exp_q.pop_front());
            end else begin
               chk("dout_idle", DOut, 64'd0);
            end
         end
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clk);
         #2;
      end
   endtask

   initial begin
      Reset = 1'b1; Req = 1'b0; DReady = 1'b1; Cnt0 = 64'd0; Cnt1 = 64'd0;
      tick(3);
      Reset = 1'b0;
      tick(2);

      // Basic frame
      Cnt0 = 64'h0102030405060708; Cnt1 = 64'd0; Req = 1'b1;
      tick(1);
      Req = 1'b0;
      tick(FLEN + 3);

      // Snapshot stability, stall on data byte 3, busy request on data byte 5
      Req = 1'b1;
      tick(1);
      Req = 1'b0; Cnt0 = '1;
      tick(4);
      DReady = 1'b0;
      tick(5);
      DReady = 1'b1;
      tick(2);
      Req = 1'b1;
      tick(1);
      Req = 1'b0;
      tick(FLEN);

      // Reset during data byte 10, then a fresh frame
      Cnt0 = 64'h1122334455667788; Cnt1 = 64'h99AABBCCDDEEFF00; Req = 1'b1;
      tick(1);
      Req = 1'b0;
      tick(11);
      Reset = 1'b1;
      tick(1);
      Reset = 1'b0;
      tick(2);
      Req = 1'b1;
      tick(1);
      Req = 1'b0;
      tick(FLEN + 2);

      // Back-to-back: Req on the last-accept edge is dropped, next cycle starts anew
      Cnt0 = 64'hDEADBEEFCAFEF00D; Cnt1 = 64'h0123456789ABCDEF; Req = 1'b1;
      tick(1);
      Req = 1'b0;
      tick(FLEN - 1);
      Req = 1'b1;
      tick(1);
      Cnt0 = 64'hFEDCBA9876543210; Cnt1 = 64'h5A5A5A5AA5A5A5A5;
      tick(1);
      Req = 1'b0;
      tick(FLEN + 2);

      // Randomized traffic
      for (int c = 0; c < 800; c++) begin
         Req    = ($urandom_range(0, 7) == 0);
         DReady = ($urandom_range(0, 3) != 0);
         Reset  = ($urandom_range(0, 149) == 0);
         Cnt0   = {$urandom, $urandom};
         Cnt1   = {$urandom, $urandom};
         tick(1);
      end

      Reset = 1'b0; Req = 1'b0; DReady = 1'b1;
      tick(FLEN + 3);
      chk("drain_busy", Busy, 64'd0);
      chk("drain_dvalid", DValid, 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
